// File: rtl/group_result.sv
// Consumer of group_mac result words: buffers one GROUP_NB-lane word, rescales each lane to image fixed point and streams the lanes out one per beat.
// Optional GROUP_RESULT_RELU_EN clamps negative converted lanes to zero.
module group_result #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 8,
  parameter int KER_FIXED = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [GROUP_NB*(IMG_WIDTH+KER_WIDTH+1)-1:0]   result,
  input  logic                                          result_val,
  output logic                                          result_rdy,
  output logic [IMG_WIDTH-1:0]                          str_data,
  output logic                                          str_last,
  output logic                                          str_val,
  input  logic                                          str_rdy
);

  localparam int RES_W = IMG_WIDTH + KER_WIDTH + 1;
  localparam int BUF_W = GROUP_NB * RES_W;
  localparam int IDX_W = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_NB - 1);

  localparam int RND_SH = (KER_FIXED > 0) ? KER_FIXED - 1 : 0;
  localparam logic [RES_W:0] RND = (KER_FIXED > 0) ? ((RES_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [RES_W:0] SAT_HI = (RES_W+1)'((64'sd1 <<< (IMG_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RES_W:0] SAT_LO = -SAT_HI - (RES_W+1)'(1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_SEND = 1'b1;

  logic                 state_q, state_d;
  logic                 result_rdy_q, result_rdy_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 str_val_q, str_val_d;
  logic                 str_last_q, str_last_d;
  logic [IMG_WIDTH-1:0] str_data_q, str_data_d;

  // Round half up, arithmetic shift, then saturate to the signed image width.
  function automatic logic [IMG_WIDTH-1:0] conv(input logic [RES_W-1:0] x);
    logic signed [RES_W:0] ext;
    logic signed [RES_W:0] sum;
    logic signed [RES_W:0] y;
    logic [IMG_WIDTH-1:0]  r;
    ext = {x[RES_W-1], x};
    sum = ext + $signed(RND);
    y   = sum >>> KER_FIXED;
    if (y > SAT_HI) begin
      r = {1'b0, {(IMG_WIDTH-1){1'b1}}};
    end else if (y < SAT_LO) begin
      r = {1'b1, {(IMG_WIDTH-1){1'b0}}};
    end else begin
      r = y[IMG_WIDTH-1:0];
    end
`ifdef GROUP_RESULT_RELU_EN
    if (r[IMG_WIDTH-1]) begin
      r = '0;
    end
`else
`endif
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    result_rdy_d = result_rdy_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    str_val_d    = str_val_q;
    str_last_d   = str_last_q;
    str_data_d   = str_data_q;
    case (state_q)
      S_IDLE: begin
        if (result_val && result_rdy_q) begin
          // Lane 0 is converted straight from the input so it is presented the cycle after capture.
          buf_d        = result;
          idx_d        = '0;
          state_d      = S_SEND;
          result_rdy_d = 1'b0;
          str_val_d    = 1'b1;
          str_last_d   = (GROUP_NB == 1);
          str_data_d   = conv(result[RES_W-1:0]);
        end
      end
      S_SEND: begin
        if (str_val_q && str_rdy) begin
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_q + IDX_W'(1);
            str_data_d = conv(buf_q[int'(idx_d)*RES_W +: RES_W]);
            str_last_d = (idx_d == LAST_IDX);
          end else begin
            str_val_d    = 1'b0;
            str_last_d   = 1'b0;
            state_d      = S_IDLE;
            result_rdy_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      result_rdy_q <= 1'b1;
      buf_q        <= '0;
      idx_q        <= '0;
      str_val_q    <= 1'b0;
      str_last_q   <= 1'b0;
      str_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      result_rdy_q <= result_rdy_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      str_val_q    <= str_val_d;
      str_last_q   <= str_last_d;
      str_data_q   <= str_data_d;
    end
  end

  assign result_rdy = result_rdy_q;
  assign str_val    = str_val_q;
  assign str_last   = str_last_q;
  assign str_data   = str_data_q;

endmodule

// File: tb/tb_group_result.sv
// Directed bench for group_result: conversion table plus handshake, backpressure and reset corner cases.
module tb_group_result;

  localparam int RES_W = 25;
  localparam int W     = 4 * RES_W;

  logic          clk;
  logic          rst;
  logic [W-1:0]  result;
  logic          result_val;
  logic          result_rdy;
  logic [15:0]   str_data;
  logic          str_last;
  logic          str_val;
  logic          str_rdy;

  int tests;
  int fails;

  group_result dut (
    .clk        (clk),
    .rst        (rst),
    .result     (result),
    .result_val (result_val),
    .result_rdy (result_rdy),
    .str_data   (str_data),
    .str_last   (str_last),
    .str_val    (str_val),
    .str_rdy    (str_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [RES_W-1:0] lane0;
    logic [15:0]             exp;
    string                   name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic signed [RES_W-1:0] l3, input logic signed [RES_W-1:0] l2,
                                      input logic signed [RES_W-1:0] l1, input logic signed [RES_W-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic send(input logic [W-1:0] word);
    int waited;
    waited = 0;
    while (!result_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!result_rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: result_rdy stayed 0, expected 1");
    end
    result     = word;
    result_val = 1'b1;
    @(negedge clk);
    result_val = 1'b0;
  endtask

  // Drains four beats with str_rdy high, then checks return to idle.
  task automatic collect(input string name, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    str_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_val%0d", name, i), 32'(str_val), 32'd1);
      chk($sformatf("%s_dat%0d", name, i), 32'(str_data), 32'(ex[i]));
      chk($sformatf("%s_last%0d", name, i), 32'(str_last), (i == 3) ? 32'd1 : 32'd0);
      if (i == 0) chk($sformatf("%s_rdy_busy", name), 32'(result_rdy), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("%s_val_end", name), 32'(str_val), 32'd0);
    chk($sformatf("%s_rdy_end", name), 32'(result_rdy), 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] neg_sat;
    logic [15:0] neg_one;
    logic [15:0] held;
`ifdef GROUP_RESULT_RELU_EN
    neg_sat = 16'h0000;
    neg_one = 16'h0000;
`else
    neg_sat = 16'h8000;
    neg_one = 16'hFFFF;
`endif
    vecs[0] = '{lane0: 25'sd24,       exp: 16'h0002, name: "rnd_24"};
    vecs[1] = '{lane0: -25'sd24,      exp: neg_one,  name: "rnd_m24"};
    vecs[2] = '{lane0: 25'sd7,        exp: 16'h0000, name: "rnd_7"};
    vecs[3] = '{lane0: 25'sd8,        exp: 16'h0001, name: "rnd_8"};
    vecs[4] = '{lane0: 25'sh100000,   exp: 16'h7FFF, name: "sat_pos"};
    vecs[5] = '{lane0: -25'sh100000,  exp: neg_sat,  name: "sat_neg"};

    tests = 0;
    fails = 0;
    rst = 1'b1;
    result = '0;
    result_val = 1'b0;
    str_rdy = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_rdy", 32'(result_rdy), 32'd1);
    chk("reset_val", 32'(str_val), 32'd0);
    chk("reset_dat", 32'(str_data), 32'd0);
    chk("reset_last", 32'(str_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    str_rdy = 1'b1;
    send(mk(25'sd512, 25'sd384, 25'sd256, 25'sd128));
    collect("nominal", 16'h0008, 16'h0010, 16'h0018, 16'h0020);

    for (int v = 0; v < 6; v++) begin
      send(mk(25'sd0, 25'sd0, 25'sd0, vecs[v].lane0));
      collect(vecs[v].name, vecs[v].exp, 16'h0000, 16'h0000, 16'h0000);
    end

    // Backpressure on alternate cycles with a competing word held upstream.
    str_rdy = 1'b0;
    send(mk(25'sd512, 25'sd384, 25'sd256, 25'sd128));
    result     = mk(25'sd160, 25'sd160, 25'sd160, 25'sd160);
    result_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      held = 16'((i + 1) * 8);
      chk($sformatf("bp_val%0d", i), 32'(str_val), 32'd1);
      chk($sformatf("bp_dat%0d", i), 32'(str_data), 32'(held));
      @(negedge clk);
      chk($sformatf("bp_hold_dat%0d", i), 32'(str_data), 32'(held));
      chk($sformatf("bp_hold_last%0d", i), 32'(str_last), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("bp_rdy%0d", i), 32'(result_rdy), 32'd0);
      str_rdy = 1'b1;
      @(negedge clk);
      str_rdy = 1'b0;
    end
    result_val = 1'b0;
    chk("bp_val_end", 32'(str_val), 32'd0);
    @(negedge clk);
    chk("bp_no_capture", 32'(str_val), 32'd0);
    chk("bp_rdy_end", 32'(result_rdy), 32'd1);

    // Reset after lane 1 has been accepted.
    str_rdy = 1'b1;
    send(mk(25'sd512, 25'sd384, 25'sd256, 25'sd128));
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_dat", 32'(str_data), 32'h0018);
    rst = 1'b1;
    #1;
    chk("mid_rst_val", 32'(str_val), 32'd0);
    chk("mid_rst_rdy", 32'(result_rdy), 32'd1);
    chk("mid_rst_dat", 32'(str_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(mk(25'sd64, 25'sd48, 25'sd32, 25'sd16));
    collect("after_rst", 16'h0001, 16'h0002, 16'h0003, 16'h0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/group_result.md
Name: group_result

Overview:
- Consumer end of the group_mac result interface.
- Captures one GROUP_NB-lane accumulated result word.
- Rescales each lane from product fixed point (IMG_FIXED+KER_FIXED fractional bits) back to image fixed point, with rounding and saturation.
- Streams the lanes out one per beat on a valid/ready stream toward the output image buffer.

Parameters:
- GROUP_NB, 4, number of lanes per result word.
- IMG_WIDTH, 16, output/image sample width (signed).
- KER_WIDTH, 8, kernel width; sets lane width RES_W = IMG_WIDTH+KER_WIDTH+1 (25 by default).
- KER_FIXED, 4, kernel fractional bits; right-shift applied to each lane.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- result  in  GROUP_NB*RES_W  packed signed lanes, lane i at [i*RES_W +: RES_W].
- result_val  in  1  result word valid.
- result_rdy  out  1  block can accept a result word.
- str_data  out  IMG_WIDTH  converted signed lane.
- str_last  out  1  high on the beat carrying lane GROUP_NB-1.
- str_val  out  1  stream beat valid.
- str_rdy  in  1  downstream accepts beat.

Behaviour:
- Interface decided: single clock clk; rst asynchronous active-high.
- Reset values:
  - state=IDLE; result_rdy=1.
  - str_val=0, str_last=0, str_data=0.
  - Lane buffer and lane index cleared.
- FSM states IDLE and SEND:
  - result_rdy = (state==IDLE), registered.
  - IDLE: result_val&result_rdy latches all lanes into the buffer, sets idx=0 and goes to SEND. str_val rises the next cycle with lane 0.
  - SEND: str_data=conv(lane idx), str_last=(idx==GROUP_NB-1), str_val=1.
  - On str_val&str_rdy: if idx<GROUP_NB-1, idx+1 and the next lane is presented the following cycle. Otherwise drop str_val and return to IDLE; result_rdy=1 the following cycle.
  - No str_rdy: str_data, str_last and str_val hold stable (no drop, no change).
  - result_val while in SEND is ignored (result_rdy=0); upstream must hold it.
- Throughput: minimum GROUP_NB+1 cycles per result word. Latency from capture to first beat is 1 cycle.
- conv(x):
  - Compute in RES_W+1 bits: y = (x + 2^(KER_FIXED-1)) >>> KER_FIXED (round half up, arithmetic shift).
  - Saturate y to signed IMG_WIDTH: y > 2^(IMG_WIDTH-1)-1 gives 0x7FFF; y < -2^(IMG_WIDTH-1) gives 0x8000.
  - Conversion is applied to buffered lanes; the stream output is registered.
- KER_FIXED=0: no rounding term, shift 0, saturation only.
- GROUP_NB=1: every beat has str_last=1.
- rst mid-SEND: immediate return to reset values; the partial group is discarded.

Optional Feature:
- Macro GROUP_RESULT_RELU_EN.
- Defined: after saturation, any negative converted lane outputs 0 (ReLU). Positive values are unchanged.
- Undefined: signed values pass through unchanged.
- Handshake and timing are identical in both cases.

Test Plan:
- Reset: assert rst 6 cycles -> result_rdy=1, str_val=0, str_data=0.
- Nominal: lanes {512,384,256,128} (lanes 3..0), result_val one cycle, str_rdy=1.
  - Next cycle: str_data 0x0008,0x0010,0x0018,0x0020 on consecutive cycles.
  - str_last only on 0x0020.
  - result_rdy back high one cycle after the last beat.
- Rounding: lane0=24 gives 0x0002; lane0=-24 gives 0xFFFF (-1); lane0=7 gives 0x0000; lane0=8 gives 0x0001.
- Saturation: lane0=0x100000 gives 0x7FFF; lane0=-0x100000 gives 0x8000.
  - With GROUP_RESULT_RELU_EN defined, the negative case gives 0x0000 and -24 gives 0x0000.
- Backpressure: str_rdy low on alternate cycles -> each lane held stable until accepted, order 0..3 preserved. A second result_val during SEND is not captured.
- Reset mid-operation: rst after lane 1 accepted -> str_val=0 immediately, result_rdy=1. A new word then streams from lane 0.
